// File: rtl/controller_op_stack_if.sv
// Operator-stack bus between the calculator controller and its LIFO.
//   master : controller side, drives push/pop/clear strobes and wdata,
//            reads top-of-stack, count and status flags.
//   slave  : stack side, the mirror image.
interface controller_op_stack_if #(
  parameter int AW   = 4,
  parameter int CO_N = 4
);
  logic            op_push;
  logic            op_pop;
  logic            op_clear;
  logic [CO_N-1:0] op_wdata;
  logic [CO_N-1:0] op_data;
  logic            op_empty;
  logic            op_full;
  logic [AW:0]     op_count;
  logic            op_ovf;
  logic            op_udf;

  modport master (
    output op_push, op_pop, op_clear, op_wdata,
    input  op_data, op_empty, op_full, op_count, op_ovf, op_udf
  );

  modport slave (
    input  op_push, op_pop, op_clear, op_wdata,
    output op_data, op_empty, op_full, op_count, op_ovf, op_udf
  );
endinterface

// File: rtl/controller_op_stack.sv
// Operator stack for the calculator controller: a 2**AW deep LIFO of
// CO_N-bit operator codes with a registered top-of-stack, registered
// count/empty/full and sticky overflow/underflow flags.
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high
//   op    : slave side of controller_op_stack_if (strobes in, status out)
module controller_op_stack #(
  parameter int              AW    = 4,
  parameter int              CO_N  = 4,
  parameter logic [CO_N-1:0] CO_NO = '0  // "no operator" code shown when empty
) (
  input  logic                   Clock,
  input  logic                   Reset,
  controller_op_stack_if.slave   op
);

  localparam int          DEPTH  = 1 << AW;
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

  logic [CO_N-1:0] mem_q [DEPTH];
  logic [CO_N-1:0] mem_d [DEPTH];
  logic [AW:0]     cnt_q, cnt_d;
  logic [CO_N-1:0] data_q, data_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  // Pointers use only the low AW bits: at full count those bits are zero,
  // so top/below wrap naturally to DEPTH-1 / DEPTH-2.
  logic [AW-1:0] wr_ptr, top_ptr, below_ptr;
  assign wr_ptr    = cnt_q[AW-1:0];
  assign top_ptr   = cnt_q[AW-1:0] - AW'(1);
  assign below_ptr = cnt_q[AW-1:0] - AW'(2);

  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (op.op_clear) begin
      // Array contents left as-is; count reset makes them unreachable.
      cnt_d  = '0;
      data_d = CO_NO;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      unique case ({op.op_push, op.op_pop})
        2'b10: begin
          if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            mem_d[wr_ptr] = op.op_wdata;
            cnt_d         = cnt_q + 1'b1;
            data_d        = op.op_wdata;
          end
        end
        2'b01: begin
          if (empty_q) begin
            udf_d = 1'b1;
          end else begin
            cnt_d  = cnt_q - 1'b1;
            data_d = (cnt_q >= (AW+1)'(2)) ? mem_q[below_ptr] : CO_NO;
          end
        end
        2'b11: begin
          if (empty_q) begin
            // Nothing to replace: acts as a plain push, but the pop half
            // still counts as an underflow.
            mem_d[wr_ptr] = op.op_wdata;
            cnt_d         = cnt_q + 1'b1;
            udf_d         = 1'b1;
          end else begin
            mem_d[top_ptr] = op.op_wdata;
          end
          data_d = op.op_wdata;
        end
        default: ;
      endcase
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q   <= '0;
      data_q  <= CO_NO;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage carries no reset; contents are don't-care while unreachable.
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

  assign op.op_data  = data_q;
  assign op.op_empty = empty_q;
  assign op.op_full  = full_q;
  assign op.op_count = cnt_q;
  assign op.op_ovf   = ovf_q;
  assign op.op_udf   = udf_q;

endmodule

// File: doc/controller_op_stack.md
# controller_op_stack

Operator stack for the calculator controller: a synchronous LIFO that holds pending operator codes (`CO_N` wide) while shunting-yard evaluation waits on precedence decisions. The controller register logic consumes its `op_data`/`op_empty` outputs and drives its `op_push`/`op_pop`/`op_clear` strobes. Storage is a register array with a registered top-of-stack output and sticky overflow/underflow flags that the controller maps to error states.

## Interface
- `AW`, default 4: address width; depth = 2**AW entries (16).
- `Clock`  input  1  system clock; all state changes on rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `op_push`  input  1  push `op_wdata` this cycle.
- `op_pop`  input  1  pop top entry this cycle.
- `op_clear`  input  1  empty the stack and clear flags; overrides push/pop.
- `op_wdata`  input  `CO_N`  operator code to push.
- `op_data`  output  `CO_N`  registered top-of-stack; `CO_NO` when empty.
- `op_empty`  output  1  registered; 1 when count == 0.
- `op_full`  output  1  registered; 1 when count == 2**AW.
- `op_count`  output  AW+1  registered entry count, 0..2**AW.
- `op_ovf`  output  1  sticky: push attempted while full (without pop).
- `op_udf`  output  1  sticky: pop attempted while empty.

## Operation
- Internal: array `mem[0..2**AW-1]` of `CO_N` bits, stack pointer `sp` = `op_count`; top entry is `mem[sp-1]`.
- Priority per cycle: `Reset` > `op_clear` > push/pop combinations.
- `op_clear`: count←0, `op_ovf`←0, `op_udf`←0, `op_data`←`CO_NO`; array untouched.
- Push only, not full: `mem[sp]`←`op_wdata`, count+1, `op_data`←`op_wdata`.
- Push only, full: no change to array/count/`op_data`; `op_ovf`←1.
- Pop only, not empty: count−1; `op_data`←`mem[sp-2]` if count ≥ 2, else `CO_NO`.
- Pop only, empty: no change; `op_udf`←1.
- Push+pop, not empty (incl. full): replace top, `mem[sp-1]`←`op_wdata`, count unchanged, `op_data`←`op_wdata`; no flag set.
- Push+pop, empty: behaves as push (count 0→1, `op_data`←`op_wdata`) and `op_udf`←1.
- Sticky flags only cleared by `Reset` or `op_clear`; operation continues normally while set.
- `op_empty`/`op_full` derived from the next count and registered alongside it; never combinationally from inputs.

## Timing
- Reset values: `op_count`=0, `op_empty`=1, `op_full`=0, `op_data`=`CO_NO`, `op_ovf`=0, `op_udf`=0; array contents don't-care.
- Reset asserted mid-operation: all outputs take reset values at that edge regardless of strobes.
- Latency: strobes sampled at edge N; all outputs reflect the result from edge N (visible during cycle N+1). `op_data` is stable for the full cycle, so controller reads top and issues `op_pop` in the same cycle.
- Back-to-back push/pop every cycle supported; no bubbles, no handshake beyond strobes.
- Strobes are single-cycle level-sampled; a strobe held high N cycles performs N operations.
- Count never wraps: saturates at 0 and 2**AW via ignore rules above.

## Test plan
- Reset: assert `Reset` 2 cycles with `op_push`=1 -> `op_count`=0, `op_empty`=1, `op_data`=`CO_NO`, flags 0.
- LIFO order: push 1,2,3 on consecutive cycles -> `op_data` 1,2,3, count 3; pop ×3 -> `op_data` 2,1,`CO_NO`, `op_empty`=1 after third pop.
- Full/overflow: push 16 values (k=1..16 mod code range) -> `op_full`=1, count 16; 17th push -> count 16, `op_data` unchanged, `op_ovf`=1; pop -> `op_full`=0, `op_ovf` still 1.
- Underflow: pop on empty -> `op_udf`=1, count 0; then push+pop with wdata=2 on empty -> count 1, `op_data`=2, `op_udf`=1.
- Replace: stack [1,2], push+pop wdata=3 -> count 2, `op_data`=3; pop -> `op_data`=1.
- Clear priority: stack with 5 entries and `op_ovf`=1, assert `op_clear`+`op_push` -> count 0, `op_empty`=1, `op_data`=`CO_NO`, `op_ovf`=0.
